// File: rtl/cache_pkg.sv
// Shared constants, width helpers and sweep-state encoding for the cache tag
// store and the controller that drives it.
package cache_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } sweep_state_t;

    function automatic int way_width(input int ways);
        return (ways > 1) ? $clog2(ways) : 1;
    endfunction

    function automatic int sets(input int index_width);
        return 1 << index_width;
    endfunction

endpackage

// File: rtl/tag_way.sv
// One way of the tag store: per-set tag/valid/mod/lru storage with a
// combinational read port and the tag comparator for that way.
module tag_way
    import cache_pkg::*;
#(
    parameter int TAG_WIDTH   = 8,
    parameter int INDEX_WIDTH = 4,
    parameter int WAY_WIDTH   = 3,
    parameter int WAY_ID      = 0
) (
    input  logic                   clk,
    input  logic [INDEX_WIDTH-1:0] index,
    input  logic [TAG_WIDTH-1:0]   tag_in,
    input  logic                   wr,
    input  logic                   mod_new,
    input  logic                   lru_wr,
    input  logic [WAY_WIDTH-1:0]   lru_new,
    input  logic                   clr,
    input  logic [INDEX_WIDTH-1:0] clr_index,
    output logic                   match,
    output logic [TAG_WIDTH-1:0]   tag,
    output logic                   valid,
    output logic                   mod,
    output logic [WAY_WIDTH-1:0]   lru
);

    localparam int SETS = sets(INDEX_WIDTH);

    logic [TAG_WIDTH-1:0] tag_mem [SETS];
    logic [WAY_WIDTH-1:0] lru_mem [SETS];
    logic [SETS-1:0]      valid_mem;
    logic [SETS-1:0]      mod_mem;

    // NOTE: the arrays have no reset branch; the sweep initialises every set,
    // so they can map onto plain storage with no reset fan-out.
    // NOTE: state is updated with <= so every flop samples pre-edge values
    // no matter how processes are ordered.
    always_ff @(posedge clk) begin
        if (clr) begin
            tag_mem[clr_index]   <= '0;
            valid_mem[clr_index] <= 1'b0;
            mod_mem[clr_index]   <= 1'b0;
            lru_mem[clr_index]   <= WAY_WIDTH'(WAY_ID);
        end else begin
            if (wr) begin
                tag_mem[index]   <= tag_in;
                valid_mem[index] <= 1'b1;
                mod_mem[index]   <= mod_new;
            end
            if (lru_wr) begin
                lru_mem[index] <= lru_new;
            end
        end
    end

    assign tag   = tag_mem[index];
    assign valid = valid_mem[index];
    assign mod   = mod_mem[index];
    assign lru   = lru_mem[index];
    assign match = valid && (tag == tag_in);

endmodule

// File: rtl/tag_memory_nway.sv
// N-way set-associative tag store with true-LRU replacement, invalid-first
// victim choice and a set-by-set invalidate sweep on reset or flush.
module tag_memory_nway
    import cache_pkg::*;
#(
    parameter int TAG_WIDTH   = 8,
    parameter int INDEX_WIDTH = 4,
    parameter int WAYS        = 8,
    parameter int WAY_WIDTH   = way_width(WAYS)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [TAG_WIDTH-1:0]   tag_in,
    input  logic [INDEX_WIDTH-1:0] index,
    input  logic                   wr,
    input  logic                   mod_in,
    input  logic                   age,
    input  logic                   flush,
    output logic                   busy,
    output logic                   hit,
    output logic [WAY_WIDTH-1:0]   chan,
    output logic [WAY_WIDTH-1:0]   age_chan,
    output logic [TAG_WIDTH-1:0]   age_tag,
    output logic                   age_mod,
    output logic                   age_valid
);

    localparam int                     SETS     = sets(INDEX_WIDTH);
    localparam logic [WAY_WIDTH-1:0]   LRU_LAST = WAY_WIDTH'(WAYS - 1);
    localparam logic [INDEX_WIDTH-1:0] LAST_SET = INDEX_WIDTH'(SETS - 1);

    sweep_state_t           state, state_next;
    logic [INDEX_WIDTH-1:0] set_cnt, set_cnt_next;
    logic                   sweeping;
    logic                   active;

    logic [WAYS-1:0]      match, valid, mod, wr_way;
    logic [TAG_WIDTH-1:0] tag [WAYS];
    logic [WAY_WIDTH-1:0] lru [WAYS];
    logic [WAY_WIDTH-1:0] lru_new [WAYS];

    logic                 hit_raw;
    logic [WAY_WIDTH-1:0] chan_raw, victim, ref_way, ref_lru;
    logic                 has_invalid, mod_new, lru_wr;

    // ---------------- sweep FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= SWEEP;
            set_cnt <= '0;
        end else begin
            state   <= state_next;
            set_cnt <= set_cnt_next;
        end
    end

    always_comb begin
        // NOTE: defaults first so no path through the case leaves a value
        // unassigned, which would otherwise infer a latch.
        state_next   = state;
        set_cnt_next = set_cnt;
        unique case (state)
            IDLE: begin
                if (flush) begin
                    state_next   = SWEEP;
                    set_cnt_next = '0;
                end
            end
            SWEEP: begin
                set_cnt_next = set_cnt + 1'b1;
                if (set_cnt == LAST_SET) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign sweeping = (state == SWEEP) && !rst;
    assign active   = (state == IDLE) && !rst;

    // ---------------- ways ----------------
    for (genvar w = 0; w < WAYS; w++) begin : g_way
        tag_way #(
            .TAG_WIDTH  (TAG_WIDTH),
            .INDEX_WIDTH(INDEX_WIDTH),
            .WAY_WIDTH  (WAY_WIDTH),
            .WAY_ID     (w)
        ) u_way (
            .clk      (clk),
            .index    (index),
            .tag_in   (tag_in),
            .wr       (wr_way[w]),
            .mod_new  (mod_new),
            .lru_wr   (lru_wr),
            .lru_new  (lru_new[w]),
            .clr      (sweeping),
            .clr_index(set_cnt),
            .match    (match[w]),
            .tag      (tag[w]),
            .valid    (valid[w]),
            .mod      (mod[w]),
            .lru      (lru[w])
        );
    end

    // ---------------- hit encoder and victim select ----------------
    always_comb begin
        hit_raw     = 1'b0;
        chan_raw    = '0;
        has_invalid = 1'b0;
        victim      = '0;
        // Descending scans leave the lowest qualifying way as the final winner.
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (match[w]) begin
                hit_raw  = 1'b1;
                chan_raw = WAY_WIDTH'(w);
            end
        end
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid[w]) begin
                has_invalid = 1'b1;
                victim      = WAY_WIDTH'(w);
            end
        end
        if (!has_invalid) begin
            for (int w = 0; w < WAYS; w++) begin
                if (lru[w] == LRU_LAST) begin
                    victim = WAY_WIDTH'(w);
                end
            end
        end
    end

    // ---------------- write / LRU update ----------------
    assign ref_way = hit_raw ? chan_raw : victim;
    assign ref_lru = lru[ref_way];
    assign mod_new = mod_in | (hit_raw & mod[ref_way]);
    assign lru_wr  = active && age;

    always_comb begin
        for (int w = 0; w < WAYS; w++) begin
            wr_way[w]  = active && wr && (ref_way == WAY_WIDTH'(w));
            lru_new[w] = lru[w];
            if (ref_way == WAY_WIDTH'(w)) begin
                lru_new[w] = '0;
            end else if (lru[w] < ref_lru) begin
                lru_new[w] = lru[w] + 1'b1;
            end
        end
    end

    // ---------------- outputs, forced quiet while busy ----------------
    assign busy      = !active;
    assign hit       = active && hit_raw;
    assign chan      = active ? chan_raw : '0;
    assign age_chan  = active ? victim : '0;
    assign age_tag   = active ? tag[victim] : '0;
    assign age_mod   = active && mod[victim];
    assign age_valid = active && valid[victim];

endmodule

// File: tb/tb_tag_memory_nway.sv
// Bench for tag_memory_nway: directed 8-way vectors through a scoreboard
// queue, sweep timing sequences, and 2-/16-way random traffic against a model.
`timescale 1ns/1ps
module tb_tag_memory_nway;

    int n_tests = 0;
    int n_fail  = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- 8-way instance ----------------
    logic       rst = 1'b1, wr = 1'b0, mod_in = 1'b0, age = 1'b0, flush = 1'b0;
    logic [7:0] tag_in = '0;
    logic [3:0] index = '0;
    logic       busy, hit, age_mod, age_valid;
    logic [2:0] chan, age_chan;
    logic [7:0] age_tag;

    tag_memory_nway #(.TAG_WIDTH(8), .INDEX_WIDTH(4), .WAYS(8)) dut (
        .clk(clk), .rst(rst), .tag_in(tag_in), .index(index), .wr(wr),
        .mod_in(mod_in), .age(age), .flush(flush), .busy(busy), .hit(hit),
        .chan(chan), .age_chan(age_chan), .age_tag(age_tag),
        .age_mod(age_mod), .age_valid(age_valid)
    );

    // ---------------- 2-way and 16-way instances, shared stimulus ----------------
    logic       r_rst = 1'b1, r_wr = 1'b0, r_mod = 1'b0, r_age = 1'b0, r_flush = 1'b0;
    logic [2:0] r_tag = '0;
    logic [1:0] r_index = '0;
    logic       a_busy, a_hit, a_mod, a_valid;
    logic [0:0] a_chan, a_achan;
    logic [2:0] a_tag;
    logic       b_busy, b_hit, b_mod, b_valid;
    logic [3:0] b_chan, b_achan;
    logic [2:0] b_tag;

    tag_memory_nway #(.TAG_WIDTH(3), .INDEX_WIDTH(2), .WAYS(2)) dut_w2 (
        .clk(clk), .rst(r_rst), .tag_in(r_tag), .index(r_index), .wr(r_wr),
        .mod_in(r_mod), .age(r_age), .flush(r_flush), .busy(a_busy), .hit(a_hit),
        .chan(a_chan), .age_chan(a_achan), .age_tag(a_tag),
        .age_mod(a_mod), .age_valid(a_valid)
    );

    tag_memory_nway #(.TAG_WIDTH(3), .INDEX_WIDTH(2), .WAYS(16)) dut_w16 (
        .clk(clk), .rst(r_rst), .tag_in(r_tag), .index(r_index), .wr(r_wr),
        .mod_in(r_mod), .age(r_age), .flush(r_flush), .busy(b_busy), .hit(b_hit),
        .chan(b_chan), .age_chan(b_achan), .age_tag(b_tag),
        .age_mod(b_mod), .age_valid(b_valid)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- directed vectors and scoreboard ----------------
    typedef struct {
        logic       busy, hit;
        logic [2:0] chan, achan;
        logic [7:0] atag;
        logic       amod, avalid;
    } outs_t;

    typedef struct {
        string      name;
        logic [3:0] index;
        logic [7:0] tag;
        logic       wr, mod_in, age;
        outs_t      exp;
    } vec_t;

    outs_t exp_q[$];
    vec_t  vecs[$];

    function automatic vec_t mk(input string name, input int idx, input int t,
                                input bit w, input bit m, input bit a,
                                input bit h, input int c, input int ac,
                                input int at, input bit am, input bit av);
        vec_t v;
        v.name = name; v.index = 4'(idx); v.tag = 8'(t);
        v.wr = w; v.mod_in = m; v.age = a;
        v.exp.busy = 1'b0; v.exp.hit = h; v.exp.chan = 3'(c); v.exp.achan = 3'(ac);
        v.exp.atag = 8'(at); v.exp.amod = am; v.exp.avalid = av;
        return v;
    endfunction

    task automatic compare_main(input string name);
        outs_t e;
        if (exp_q.size() == 0) begin
            check({name, ".queue"}, 32'd0, 32'd1);
            return;
        end
        e = exp_q.pop_front();
        check({name, ".busy"},      busy,      e.busy);
        check({name, ".hit"},       hit,       e.hit);
        check({name, ".chan"},      chan,      e.chan);
        check({name, ".age_chan"},  age_chan,  e.achan);
        check({name, ".age_valid"}, age_valid, e.avalid);
        check({name, ".age_mod"},   age_mod,   e.amod);
        if (e.avalid) check({name, ".age_tag"}, age_tag, e.atag);
    endtask

    task automatic apply_vec(input vec_t v);
        @(posedge clk); #1;
        index = v.index; tag_in = v.tag; wr = v.wr; mod_in = v.mod_in; age = v.age;
        exp_q.push_back(v.exp);
        @(negedge clk);
        compare_main(v.name);
    endtask

    task automatic count_busy(output int n);
        n = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (busy) n++;
            else break;
        end
    endtask

    task automatic check_quiet(input string name);
        check({name, ".busy"},      busy,      1);
        check({name, ".hit"},       hit,       0);
        check({name, ".age_chan"},  age_chan,  0);
        check({name, ".age_tag"},   age_tag,   0);
        check({name, ".age_valid"}, age_valid, 0);
    endtask

    // ---------------- reference model for the random instances ----------------
    logic [2:0] m_tag [2][4][16];
    bit         m_val [2][4][16];
    bit         m_mod [2][4][16];
    int         m_lru [2][4][16];
    bit         m_busy[2];
    int         m_cnt [2];

    typedef struct {
        int         k;
        logic       busy, hit;
        int         chan, achan;
        logic [2:0] atag;
        logic       amod, avalid;
    } rexp_t;

    rexp_t rq[$];

    task automatic m_lookup(input int k, input int nw, output bit h, output int c, output int v);
        int s = int'(r_index);
        h = 0; c = 0; v = -1;
        for (int w = nw - 1; w >= 0; w--)
            if (m_val[k][s][w] && m_tag[k][s][w] == r_tag) begin h = 1; c = w; end
        for (int w = 0; w < nw; w++)
            if (!m_val[k][s][w] && v < 0) v = w;
        if (v < 0)
            for (int w = 0; w < nw; w++)
                if (m_lru[k][s][w] == nw - 1) v = w;
        if (v < 0) v = 0;
    endtask

    task automatic model_exp(input int k, input int nw, output rexp_t e);
        bit h; int c, v;
        int s = int'(r_index);
        e.k = k;
        if (m_busy[k] || r_rst) begin
            e.busy = 1; e.hit = 0; e.chan = 0; e.achan = 0; e.atag = '0; e.amod = 0; e.avalid = 0;
            return;
        end
        m_lookup(k, nw, h, c, v);
        e.busy = 0; e.hit = h; e.chan = h ? c : 0; e.achan = v;
        e.atag = m_tag[k][s][v]; e.amod = m_mod[k][s][v]; e.avalid = m_val[k][s][v];
    endtask

    task automatic model_step(input int k, input int nw);
        bit h; int c, v, rw, rl;
        int s = int'(r_index);
        if (r_rst) begin
            m_busy[k] = 1; m_cnt[k] = 0;
            return;
        end
        if (m_busy[k]) begin
            for (int w = 0; w < nw; w++) begin
                m_val[k][m_cnt[k]][w] = 0; m_mod[k][m_cnt[k]][w] = 0; m_lru[k][m_cnt[k]][w] = w;
            end
            m_cnt[k]++;
            if (m_cnt[k] == 4) m_busy[k] = 0;
            return;
        end
        m_lookup(k, nw, h, c, v);
        rw = h ? c : v;
        rl = m_lru[k][s][rw];
        if (r_wr) begin
            m_mod[k][s][rw] = h ? (m_mod[k][s][rw] | r_mod) : r_mod;
            m_tag[k][s][rw] = r_tag;
            m_val[k][s][rw] = 1;
        end
        if (r_age)
            for (int w = 0; w < nw; w++) begin
                if (w == rw) m_lru[k][s][w] = 0;
                else if (m_lru[k][s][w] < rl) m_lru[k][s][w]++;
            end
        if (r_flush) begin
            m_busy[k] = 1; m_cnt[k] = 0;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rexp_t e;

        // ---- reset sweep ----
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_quiet("in_reset");
        @(posedge clk); #1 rst = 1'b0;
        count_busy(n);
        check("reset.busy_len", n, 16);
        index = 4'd9; tag_in = 8'h00; #1;
        check("post_reset.hit",       hit,       0);
        check("post_reset.age_valid", age_valid, 0);
        check("post_reset.age_chan",  age_chan,  0);

        // ---- fill, LRU eviction, dirty handling ----
        for (int i = 0; i < 8; i++)
            vecs.push_back(mk($sformatf("fill%0d", i), 3, 'h10 + i, 1, 0, 1, 0, 0, i, 0, 0, 0));
        vecs.push_back(mk("look15", 3, 'h15, 0, 0, 0, 1, 5, 0, 'h10, 0, 1));
        vecs.push_back(mk("age10",  3, 'h10, 0, 0, 1, 1, 0, 0, 'h10, 0, 1));
        vecs.push_back(mk("missAA", 3, 'hAA, 1, 0, 1, 0, 0, 1, 'h11, 0, 1));
        vecs.push_back(mk("lookAA", 3, 'hAA, 0, 0, 0, 1, 1, 2, 'h12, 0, 1));
        vecs.push_back(mk("dirty1", 3, 'h12, 1, 1, 0, 1, 2, 2, 'h12, 0, 1));
        vecs.push_back(mk("dirty2", 3, 'h12, 1, 0, 0, 1, 2, 2, 'h12, 1, 1));
        vecs.push_back(mk("dirtyv", 3, 'h99, 0, 0, 0, 0, 0, 2, 'h12, 1, 1));
        vecs.push_back(mk("miss55", 3, 'h55, 1, 0, 0, 0, 0, 2, 'h12, 1, 1));
        vecs.push_back(mk("look55", 3, 'h55, 0, 0, 0, 1, 2, 2, 'h55, 0, 1));
        vecs.push_back(mk("set4",   4, 'h15, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        foreach (vecs[i]) apply_vec(vecs[i]);
        check("scoreboard.drained", exp_q.size(), 0);

        // ---- flush while idle; writes during busy are dropped ----
        @(posedge clk); #1;
        wr = 0; age = 0; flush = 1; index = 3; tag_in = 8'h15;
        @(negedge clk);
        check("pre_flush.hit",  hit,  1);
        check("pre_flush.busy", busy, 0);
        @(posedge clk); #1;
        flush = 0; wr = 1; age = 1; tag_in = 8'h77;
        @(negedge clk);
        check_quiet("flush_busy");
        count_busy(n);
        check("flush.busy_len", n + 1, 16);
        wr = 0; age = 0; #1;
        check("post_flush.hit77",     hit,       0);
        check("post_flush.age_valid", age_valid, 0);
        tag_in = 8'h15; #1;
        check("post_flush.hit15", hit, 0);

        // ---- reset part-way through a sweep restarts it ----
        @(posedge clk); #1 flush = 1;
        @(posedge clk); #1 flush = 0;
        repeat (6) @(posedge clk);
        #1 rst = 1;
        @(negedge clk);
        check_quiet("mid_sweep_rst");
        @(posedge clk); #1 rst = 0;
        count_busy(n);
        check("mid_rst.busy_len", n, 16);

        // ---- 2-way / 16-way random traffic against the model ----
        for (int cyc = 0; cyc < 600; cyc++) begin
            @(posedge clk);
            model_step(0, 2);
            model_step(1, 16);
            #1;
            r_rst   = (cyc != 0) && ($urandom_range(0, 199) == 0);
            r_flush = ($urandom_range(0, 59) == 0);
            r_index = 2'($urandom_range(0, 3));
            r_tag   = 3'($urandom_range(0, 7));
            r_wr    = 1'($urandom_range(0, 1));
            r_age   = 1'($urandom_range(0, 1));
            r_mod   = 1'($urandom_range(0, 1));
            model_exp(0, 2, e);  rq.push_back(e);
            model_exp(1, 16, e); rq.push_back(e);
            @(negedge clk);
            while (rq.size() > 0) begin
                e = rq.pop_front();
                if (e.k == 0) begin
                    check($sformatf("w2.busy@%0d", cyc),  a_busy,  e.busy);
                    check($sformatf("w2.hit@%0d", cyc),   a_hit,   e.hit);
                    check($sformatf("w2.chan@%0d", cyc),  a_chan,  32'(e.chan));
                    check($sformatf("w2.achan@%0d", cyc), a_achan, 32'(e.achan));
                    check($sformatf("w2.aval@%0d", cyc),  a_valid, e.avalid);
                    check($sformatf("w2.amod@%0d", cyc),  a_mod,   e.amod);
                    if (e.avalid) check($sformatf("w2.atag@%0d", cyc), a_tag, e.atag);
                end else begin
                    check($sformatf("w16.busy@%0d", cyc),  b_busy,  e.busy);
                    check($sformatf("w16.hit@%0d", cyc),   b_hit,   e.hit);
                    check($sformatf("w16.chan@%0d", cyc),  b_chan,  32'(e.chan));
                    check($sformatf("w16.achan@%0d", cyc), b_achan, 32'(e.achan));
                    check($sformatf("w16.aval@%0d", cyc),  b_valid, e.avalid);
                    check($sformatf("w16.amod@%0d", cyc),  b_mod,   e.amod);
                    if (e.avalid) check($sformatf("w16.atag@%0d", cyc), b_tag, e.atag);
                end
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
